// File: rtl/ram_ws_rs_data_ctrl.sv
// L1.5 data RAM port controller: write-priority arbitration with a bounded read-starvation guard
// and a credit-controlled response FIFO. Optional perf counters: RAM_WS_RS_DATA_CTRL_PERF_CNT_EN.
module ram_ws_rs_data_ctrl #(
  parameter int unsigned DATA_WIDTH    = 128,
  parameter int unsigned ADDR_WIDTH    = 6,
  parameter int unsigned BE_WIDTH      = DATA_WIDTH / 8,
  parameter int unsigned RESP_DEPTH    = 2,
  parameter int unsigned MAX_WR_STREAK = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  rd_req_i,
  input  logic [ADDR_WIDTH-1:0] rd_addr_i,
  output logic                  rd_gnt_o,
  output logic                  rd_rvalid_o,
  output logic [DATA_WIDTH-1:0] rd_rdata_o,
  input  logic                  rd_rready_i,
  input  logic                  wr_req_i,
  input  logic [ADDR_WIDTH-1:0] wr_addr_i,
  input  logic [DATA_WIDTH-1:0] wr_wdata_i,
  input  logic [BE_WIDTH-1:0]   wr_be_i,
  output logic                  wr_gnt_o,
  output logic                  ram_req_o,
  output logic                  ram_write_o,
  output logic [ADDR_WIDTH-1:0] ram_addr_o,
  output logic [DATA_WIDTH-1:0] ram_wdata_o,
  output logic [BE_WIDTH-1:0]   ram_be_o,
  input  logic [DATA_WIDTH-1:0] ram_rdata_i,
  output logic [31:0]           perf_rd_cnt_o,
  output logic [31:0]           perf_wr_cnt_o,
  output logic [31:0]           perf_stall_cnt_o
);

  localparam int unsigned PTR_W = (RESP_DEPTH > 1) ? $clog2(RESP_DEPTH) : 1;
  localparam int unsigned CNT_W = $clog2(RESP_DEPTH + 1);
  localparam int unsigned STK_W = $clog2(MAX_WR_STREAK + 1);

  logic [CNT_W-1:0]      count_q;
  logic [PTR_W-1:0]      rptr_q, wptr_q;
  logic                  inflight_q;
  logic [STK_W-1:0]      streak_q;
  logic [DATA_WIDTH-1:0] mem_q [RESP_DEPTH];
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [DATA_WIDTH-1:0] wdata_q;
  logic [BE_WIDTH-1:0]   be_q;

  logic                  pop, push, rd_ok, rd_elig, force_rd;
  logic [CNT_W:0]        used;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(RESP_DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  assign pop      = rd_rvalid_o & rd_rready_i;
  assign push     = inflight_q;
  // Credits count both stored and still-in-flight responses so a grant can never overflow the FIFO.
  assign used     = (CNT_W+1)'(count_q) + (CNT_W+1)'(inflight_q) - (CNT_W+1)'(pop);
  assign rd_ok    = used < (CNT_W+1)'(RESP_DEPTH);
  assign rd_elig  = rd_req_i & rd_ok;
  assign force_rd = rd_elig & (streak_q == STK_W'(MAX_WR_STREAK));
  assign wr_gnt_o = ~rst & wr_req_i & ~force_rd;
  assign rd_gnt_o = ~rst & rd_elig & ~wr_gnt_o;

  assign rd_rvalid_o = (count_q != '0);
  assign rd_rdata_o  = mem_q[rptr_q];

  assign ram_req_o   = rd_gnt_o | wr_gnt_o;
  assign ram_write_o = wr_gnt_o;

  always_comb begin
    ram_addr_o  = addr_q;
    ram_wdata_o = wdata_q;
    ram_be_o    = be_q;
    if (rst) begin
      ram_addr_o  = '0;
      ram_wdata_o = '0;
      ram_be_o    = '0;
    end else if (wr_gnt_o) begin
      ram_addr_o  = wr_addr_i;
      ram_wdata_o = wr_wdata_i;
      ram_be_o    = wr_be_i;
    end else if (rd_gnt_o) begin
      ram_addr_o  = rd_addr_i;
      ram_be_o    = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      addr_q  <= '0;
      wdata_q <= '0;
      be_q    <= '0;
    end else if (ram_req_o) begin
      addr_q  <= ram_addr_o;
      wdata_q <= ram_wdata_o;
      be_q    <= ram_be_o;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q    <= '0;
      rptr_q     <= '0;
      wptr_q     <= '0;
      inflight_q <= 1'b0;
      streak_q   <= '0;
      for (int unsigned i = 0; i < RESP_DEPTH; i++) mem_q[i] <= '0;
    end else begin
      inflight_q <= rd_gnt_o;
      if (push) begin
        mem_q[wptr_q] <= ram_rdata_i;
        wptr_q        <= ptr_inc(wptr_q);
      end
      if (pop) rptr_q <= ptr_inc(rptr_q);
      case ({push, pop})
        2'b10:   count_q <= count_q + CNT_W'(1);
        2'b01:   count_q <= count_q - CNT_W'(1);
        default: ;
      endcase
      if (!rd_elig || rd_gnt_o)
        streak_q <= '0;
      else if (wr_gnt_o && streak_q != STK_W'(MAX_WR_STREAK))
        streak_q <= streak_q + STK_W'(1);
    end
  end

  a_no_overflow: assert property (@(posedge clk) disable iff (rst)
    !(push && !pop && count_q == CNT_W'(RESP_DEPTH)));

`ifdef RAM_WS_RS_DATA_CTRL_PERF_CNT_EN
  logic [31:0] rd_cnt_q, wr_cnt_q, stall_cnt_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_cnt_q    <= '0;
      wr_cnt_q    <= '0;
      stall_cnt_q <= '0;
    end else begin
      if (rd_gnt_o)             rd_cnt_q    <= rd_cnt_q + 32'd1;
      if (wr_gnt_o)             wr_cnt_q    <= wr_cnt_q + 32'd1;
      if (rd_req_i && !rd_gnt_o) stall_cnt_q <= stall_cnt_q + 32'd1;
    end
  end

  assign perf_rd_cnt_o    = rd_cnt_q;
  assign perf_wr_cnt_o    = wr_cnt_q;
  assign perf_stall_cnt_o = stall_cnt_q;
`else
  assign perf_rd_cnt_o    = '0;
  assign perf_wr_cnt_o    = '0;
  assign perf_stall_cnt_o = '0;
`endif

endmodule

// File: tb/tb_ram_ws_rs_data_ctrl.sv
// Self-checking bench for ram_ws_rs_data_ctrl: grant table, directed corner sequences,
// and a randomized phase checked against a transaction-level arbitration/response model.
module tb_ram_ws_rs_data_ctrl;
  localparam int DW = 128;
  localparam int AW = 6;
  localparam int BW = 16;
  localparam int DEPTH = 2;
  localparam int MAXS = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          rd_req_i, rd_gnt_o, rd_rvalid_o, rd_rready_i;
  logic [AW-1:0] rd_addr_i, wr_addr_i, ram_addr_o;
  logic [DW-1:0] rd_rdata_o, wr_wdata_i, ram_wdata_o, ram_rdata_i;
  logic          wr_req_i, wr_gnt_o, ram_req_o, ram_write_o;
  logic [BW-1:0] wr_be_i, ram_be_o;
  logic [31:0]   perf_rd_cnt_o, perf_wr_cnt_o, perf_stall_cnt_o;

  int checks = 0;
  int errors = 0;

  ram_ws_rs_data_ctrl #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .BE_WIDTH(BW),
                        .RESP_DEPTH(DEPTH), .MAX_WR_STREAK(MAXS)) dut (
    .clk(clk), .rst(rst),
    .rd_req_i(rd_req_i), .rd_addr_i(rd_addr_i), .rd_gnt_o(rd_gnt_o),
    .rd_rvalid_o(rd_rvalid_o), .rd_rdata_o(rd_rdata_o), .rd_rready_i(rd_rready_i),
    .wr_req_i(wr_req_i), .wr_addr_i(wr_addr_i), .wr_wdata_i(wr_wdata_i), .wr_be_i(wr_be_i),
    .wr_gnt_o(wr_gnt_o), .ram_req_o(ram_req_o), .ram_write_o(ram_write_o),
    .ram_addr_o(ram_addr_o), .ram_wdata_o(ram_wdata_o), .ram_be_o(ram_be_o),
    .ram_rdata_i(ram_rdata_i),
    .perf_rd_cnt_o(perf_rd_cnt_o), .perf_wr_cnt_o(perf_wr_cnt_o),
    .perf_stall_cnt_o(perf_stall_cnt_o)
  );

  always #5 clk = ~clk;

  // Single-port RAM with byte enables and one-cycle read latency.
  logic [DW-1:0] ram [64];
  always @(posedge clk) begin
    if (ram_req_o) begin
      if (ram_write_o) begin
        for (int b = 0; b < BW; b++)
          if (ram_be_o[b]) ram[ram_addr_o][b*8 +: 8] <= ram_wdata_o[b*8 +: 8];
      end else begin
        ram_rdata_i <= ram[ram_addr_o];
      end
    end
  end

  task automatic chk(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    rd_req_i = 0; rd_addr_i = '0; rd_rready_i = 1;
    wr_req_i = 0; wr_addr_i = '0; wr_wdata_i = '0; wr_be_i = '0;
  endtask

  task automatic do_reset();
    rst = 1; idle();
    cycle();
    cycle();
    rst = 0;
  endtask

  task automatic wr_word(input logic [AW-1:0] a, input logic [DW-1:0] d, input logic [BW-1:0] be);
    wr_req_i = 1; wr_addr_i = a; wr_wdata_i = d; wr_be_i = be;
    @(negedge clk);
    chk("wr_word_gnt", wr_gnt_o, 1);
    cycle();
    wr_req_i = 0;
  endtask

  typedef struct {
    logic rst, rd, wr;
    logic [AW-1:0] ra, wa;
    logic [BW-1:0] be;
    logic egr, egw, ereq, ewr;
    logic [AW-1:0] eaddr;
    logic [BW-1:0] ebe;
  } vec_t;

  typedef struct {
    logic [DW-1:0] d;
    int t;
  } rsp_t;

  logic [DW-1:0] mdl_mem [64];
  rsp_t          q[$];

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t tbl[5];
    logic [DW-1:0] bp_data[4];
    logic [DW-1:0] exp_d;
    int ng, nr, cyc, streak;
    logic exp_rv, exp_pop, ok, elig, frc, exp_wr, exp_rd;

    tbl[0] = '{0, 0, 0, 6'h00, 6'h00, 16'h0000, 0, 0, 0, 0, 6'h00, 16'h0000};
    tbl[1] = '{0, 1, 0, 6'h11, 6'h00, 16'h0000, 1, 0, 1, 0, 6'h11, 16'h0000};
    tbl[2] = '{0, 0, 1, 6'h00, 6'h22, 16'hF0F0, 0, 1, 1, 1, 6'h22, 16'hF0F0};
    tbl[3] = '{0, 1, 1, 6'h11, 6'h33, 16'h00FF, 0, 1, 1, 1, 6'h33, 16'h00FF};
    tbl[4] = '{1, 1, 1, 6'h11, 6'h33, 16'h00FF, 0, 0, 0, 0, 6'h00, 16'h0000};

    rst = 1; idle();
    do_reset();
    @(negedge clk);
    chk("reset_rvalid", rd_rvalid_o, 0);
    chk("reset_rdata", rd_rdata_o, '0);
    chk("reset_ram_req", ram_req_o, 0);
    chk("reset_perf_rd", perf_rd_cnt_o, 0);
    cycle();

    foreach (tbl[i]) begin
      do_reset();
      rst = tbl[i].rst; rd_req_i = tbl[i].rd; wr_req_i = tbl[i].wr;
      rd_addr_i = tbl[i].ra; wr_addr_i = tbl[i].wa; wr_be_i = tbl[i].be;
      wr_wdata_i = {4{32'hDEAD_BEEF}};
      @(negedge clk);
      chk($sformatf("tbl%0d_rd_gnt", i), rd_gnt_o, tbl[i].egr);
      chk($sformatf("tbl%0d_wr_gnt", i), wr_gnt_o, tbl[i].egw);
      chk($sformatf("tbl%0d_ram_req", i), ram_req_o, tbl[i].ereq);
      chk($sformatf("tbl%0d_ram_write", i), ram_write_o, tbl[i].ewr);
      chk($sformatf("tbl%0d_ram_addr", i), ram_addr_o, tbl[i].eaddr);
      chk($sformatf("tbl%0d_ram_be", i), ram_be_o, tbl[i].ebe);
      cycle();
      idle(); rst = 0;
    end

    // Single read with two-cycle latency.
    do_reset();
    wr_word(6'h05, 128'hA5A5, '1);
    rd_req_i = 1; rd_addr_i = 6'h05;
    @(negedge clk);
    chk("single_rd_gnt", rd_gnt_o, 1);
    chk("single_ram_req", ram_req_o, 1);
    chk("single_ram_write", ram_write_o, 0);
    chk("single_ram_addr", ram_addr_o, 6'h05);
    chk("single_ram_be", ram_be_o, 0);
    cycle(); rd_req_i = 0;
    @(negedge clk);
    chk("single_rvalid_n1", rd_rvalid_o, 0);
    chk("single_ram_addr_hold", ram_addr_o, 6'h05);
    cycle();
    @(negedge clk);
    chk("single_rvalid_n2", rd_rvalid_o, 1);
    chk("single_rdata", rd_rdata_o, 128'hA5A5);
    cycle();
    @(negedge clk);
    chk("single_popped", rd_rvalid_o, 0);

    // Conflict: four writes then one forced read, repeating.
    do_reset();
    rd_req_i = 1; wr_req_i = 1; rd_addr_i = 6'h05; wr_addr_i = 6'h30; wr_be_i = '1;
    wr_wdata_i = 128'h77;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk($sformatf("conflict_wr_gnt_c%0d", i), wr_gnt_o, (i % 5) != 4);
      chk($sformatf("conflict_rd_gnt_c%0d", i), rd_gnt_o, (i % 5) == 4);
      cycle();
    end
    idle();
    @(negedge clk);
`ifdef RAM_WS_RS_DATA_CTRL_PERF_CNT_EN
    chk("perf_rd", perf_rd_cnt_o, 2);
    chk("perf_wr", perf_wr_cnt_o, 8);
    chk("perf_stall", perf_stall_cnt_o, 8);
`else
    chk("perf_rd_off", perf_rd_cnt_o, 0);
    chk("perf_wr_off", perf_wr_cnt_o, 0);
    chk("perf_stall_off", perf_stall_cnt_o, 0);
`endif
    cycle(); cycle();

    // Backpressure: credits stop grants at RESP_DEPTH outstanding.
    do_reset();
    for (int i = 0; i < 4; i++) begin
      bp_data[i] = {$urandom, $urandom, $urandom, $urandom};
      wr_word(AW'(i), bp_data[i], '1);
    end
    ng = 0; nr = 0;
    rd_rready_i = 0;
    for (int i = 0; i < 4; i++) begin
      rd_req_i = 1; rd_addr_i = AW'(ng);
      @(negedge clk);
      chk($sformatf("bp_gnt_c%0d", i), rd_gnt_o, i < 2);
      if (rd_gnt_o) ng++;
      cycle();
    end
    @(negedge clk);
    chk("bp_stalled_rvalid", rd_rvalid_o, 1);
    chk("bp_stalled_rdata", rd_rdata_o, bp_data[0]);
    chk("bp_stalled_gnt", rd_gnt_o, 0);
    cycle();
    rd_rready_i = 1;
    for (int i = 0; i < 20 && nr < 4; i++) begin
      rd_req_i = (ng < 4); rd_addr_i = AW'(ng);
      @(negedge clk);
      if (rd_rvalid_o) begin
        chk($sformatf("bp_rdata%0d", nr), rd_rdata_o, bp_data[nr]);
        nr++;
      end
      if (rd_gnt_o) ng++;
      cycle();
    end
    chk("bp_total_grants", ng, 4);
    chk("bp_total_responses", nr, 4);
    idle();

    // Byte-enable write then read back.
    wr_word(6'h3F, '1, '1);
    wr_req_i = 1; wr_addr_i = 6'h3F; wr_wdata_i = 128'h1122_3344; wr_be_i = 16'h000F;
    @(negedge clk);
    chk("be_ram_be", ram_be_o, 16'h000F);
    chk("be_ram_addr", ram_addr_o, 6'h3F);
    chk("be_ram_write", ram_write_o, 1);
    chk("be_ram_wdata", ram_wdata_o, 128'h1122_3344);
    cycle(); idle();
    rd_req_i = 1; rd_addr_i = 6'h3F;
    cycle(); rd_req_i = 0;
    cycle();
    @(negedge clk);
    exp_d = '1;
    exp_d[31:0] = 32'h1122_3344;
    chk("be_readback_rvalid", rd_rvalid_o, 1);
    chk("be_readback", rd_rdata_o, exp_d);
    cycle();

    // Reset in the cycle after a read grant drops the in-flight response.
    rd_req_i = 1; rd_addr_i = 6'h05;
    @(negedge clk);
    chk("rst_mid_gnt", rd_gnt_o, 1);
    cycle();
    rd_req_i = 0; rst = 1;
    @(negedge clk);
    chk("rst_mid_gnt_low", rd_gnt_o, 0);
    cycle();
    rst = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk($sformatf("rst_mid_rvalid_c%0d", i), rd_rvalid_o, 0);
      cycle();
    end
    rd_req_i = 1; rd_addr_i = 6'h05;
    @(negedge clk);
    chk("rst_after_gnt", rd_gnt_o, 1);
    cycle(); rd_req_i = 0;
    @(negedge clk);
    chk("rst_after_rvalid_n1", rd_rvalid_o, 0);
    cycle();
    @(negedge clk);
    chk("rst_after_rvalid_n2", rd_rvalid_o, 1);
    chk("rst_after_rdata", rd_rdata_o, 128'hA5A5);
    cycle();

    // Randomized traffic against a transaction-level model.
    do_reset();
    for (int a = 0; a < 64; a++) begin
      mdl_mem[a] = {$urandom, $urandom, $urandom, $urandom};
      wr_word(AW'(a), mdl_mem[a], '1);
    end
    q.delete();
    streak = 0;
    cyc = 0;
    for (int i = 0; i < 600; i++) begin
      rd_req_i    = ($urandom_range(0, 3) != 0);
      rd_addr_i   = AW'($urandom);
      wr_req_i    = ($urandom_range(0, 2) != 0);
      wr_addr_i   = AW'($urandom);
      wr_wdata_i  = {$urandom, $urandom, $urandom, $urandom};
      wr_be_i     = BW'($urandom);
      rd_rready_i = ($urandom_range(0, 3) != 0);
      @(negedge clk);
      // A response is visible two cycles after its grant; reads wait when all credits are held.
      exp_rv  = (q.size() > 0) && (q[0].t + 2 <= cyc);
      exp_pop = exp_rv && rd_rready_i;
      ok      = (q.size() - int'(exp_pop)) < DEPTH;
      elig    = rd_req_i && ok;
      frc     = elig && (streak == MAXS);
      exp_wr  = wr_req_i && !frc;
      exp_rd  = elig && !exp_wr;
      chk("rnd_wr_gnt", wr_gnt_o, exp_wr);
      chk("rnd_rd_gnt", rd_gnt_o, exp_rd);
      chk("rnd_rvalid", rd_rvalid_o, exp_rv);
      chk("rnd_ram_req", ram_req_o, exp_wr || exp_rd);
      if (exp_rv) chk("rnd_rdata", rd_rdata_o, q[0].d);
      if (exp_wr || exp_rd) chk("rnd_ram_addr", ram_addr_o, exp_wr ? wr_addr_i : rd_addr_i);
      if (exp_wr) chk("rnd_ram_be", ram_be_o, wr_be_i);
      if (exp_pop) void'(q.pop_front());
      if (exp_rd) q.push_back('{mdl_mem[rd_addr_i], cyc});
      if (exp_wr)
        for (int b = 0; b < BW; b++)
          if (wr_be_i[b]) mdl_mem[wr_addr_i][b*8 +: 8] = wr_wdata_i[b*8 +: 8];
      if (!elig || exp_rd) streak = 0;
      else if (exp_wr && streak < MAXS) streak++;
      cyc++;
      cycle();
    end
    idle();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/ram_ws_rs_data_ctrl.md
Name: ram_ws_rs_data_ctrl

Overview:
- Initiator/controller that drives the single-port L1.5 data RAM port (req/write/addr/wdata/be in, rdata out one cycle after a read request).
- Arbitrates refill write beats against fetch reads, with write priority and a bounded starvation guard for reads.
- Buffers read data in a small credit-controlled response FIFO so a stalled consumer never loses RAM output.
- Sits between the L1.5 refill/fetch logic and the data RAM.

Parameters:
- DATA_WIDTH, 128, RAM word width.
- ADDR_WIDTH, 6, RAM word address width.
- BE_WIDTH, DATA_WIDTH/8, byte-enable width.
- RESP_DEPTH, 2, response FIFO depth (>=2).
- MAX_WR_STREAK, 4, maximum consecutive write grants while a read is eligible.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- rd_req_i  in  1  fetch read request
- rd_addr_i  in  ADDR_WIDTH  read word address
- rd_gnt_o  out  1  read accepted this cycle
- rd_rvalid_o  out  1  response valid
- rd_rdata_o  out  DATA_WIDTH  response data
- rd_rready_i  in  1  consumer accepts response
- wr_req_i  in  1  refill write request
- wr_addr_i  in  ADDR_WIDTH  write word address
- wr_wdata_i  in  DATA_WIDTH  write data
- wr_be_i  in  BE_WIDTH  byte enables
- wr_gnt_o  out  1  write accepted this cycle
- ram_req_o  out  1  RAM request
- ram_write_o  out  1  1=write, 0=read
- ram_addr_o  out  ADDR_WIDTH  RAM address
- ram_wdata_o  out  DATA_WIDTH  RAM write data
- ram_be_o  out  BE_WIDTH  RAM byte enables
- ram_rdata_i  in  DATA_WIDTH  RAM read data, valid the cycle after a read request
- perf_rd_cnt_o  out  32  granted reads
- perf_wr_cnt_o  out  32  granted writes
- perf_stall_cnt_o  out  32  cycles with rd_req_i high and rd_gnt_o low

Behaviour:
- Single clock clk; reset rst is synchronous, active-high.
- Reset values: rd_rvalid_o=0, rd_rdata_o=0, ram_req_o=0, ram_write_o=0, ram_addr_o=0, ram_wdata_o=0, ram_be_o=0, FIFO empty, inflight=0, streak=0, perf counters=0.
- rd_gnt_o and wr_gnt_o are also 0 during reset.
- Read credit: rd_ok = (occupancy + inflight - pop) < RESP_DEPTH, where pop = rd_rvalid_o & rd_rready_i.
- Read eligible: rd_elig = rd_req_i & rd_ok.
- Force read: force_rd = rd_elig & (streak == MAX_WR_STREAK).
- wr_gnt_o = wr_req_i & ~force_rd.
- rd_gnt_o = rd_elig & ~wr_gnt_o.
- Grants are combinational, never both high in one cycle.
- RAM outputs are combinational from the granted channel:
  - ram_req_o = rd_gnt_o | wr_gnt_o.
  - ram_write_o = wr_gnt_o.
  - addr, wdata and be come from the winning channel.
  - On a read, ram_be_o = 0 and ram_wdata_o holds its previous value.
- Idle cycles: ram_req_o=0; ram_addr_o, ram_wdata_o and ram_be_o hold their last registered values (kept in shadow registers).
- Streak counter:
  - +1 on each write grant while rd_elig=1, saturating at MAX_WR_STREAK.
  - Cleared on a read grant, or in any cycle with rd_elig=0.
- inflight is set on the cycle after rd_gnt_o. In that cycle ram_rdata_i is pushed into the FIFO tail.
- Read latency: grant at cycle N -> rd_rvalid_o at N+2 at the earliest.
- Responses are returned in order.
- FIFO behaviour:
  - Circular, RESP_DEPTH entries, with a wrapping read pointer and write pointer.
  - Simultaneous push and pop: occupancy unchanged.
  - rd_rvalid_o = occupancy != 0, and it stays high with stable data until popped.
- Overflow is impossible by the credit rule. If overflow occurs it is an assertion failure, not handled.
- Reset mid-operation: the inflight read is discarded (the rdata arriving the next cycle is not pushed), the FIFO is cleared and the streak is cleared.
- Steady state: with RESP_DEPTH=2 and rd_rready_i held at 1, one read per cycle is sustained.

Optional Feature:
- Macro: RAM_WS_RS_DATA_CTRL_PERF_CNT_EN.
- Defined: the perf_*_cnt_o counters are live, 32-bit, wrapping at 2^32-1 -> 0, and cleared by rst.
- Undefined: the perf_*_cnt_o ports are tied to 0 and no counter flops are instantiated.

Test Plan:
- Single read: rd_req_i at addr 0x05, RAM holds 0xA5A5 -> rd_gnt_o=1 at cycle N, ram_req_o=1 and ram_write_o=0 at N, rd_rvalid_o=1 with 0xA5A5 at N+2.
- Conflict: wr_req_i and rd_req_i held high for 10 cycles -> wr_gnt_o high for 4 cycles, then rd_gnt_o for 1 cycle, repeating; perf_stall_cnt_o=8 with the macro defined.
- Backpressure: 4 back-to-back reads with rd_rready_i=0 -> exactly 2 grants, rd_gnt_o=0 thereafter. Raising rd_rready_i releases the data in order and the remaining 2 reads are granted.
- Write with byte enables: wr_be_i=0x000F with data 0x1122_3344 at addr 0x3F -> ram_be_o=0x000F and ram_addr_o=0x3F in the same cycle. A subsequent read returns only the low 4 bytes updated.
- Reset mid-flight: assert rst in the cycle after a read grant -> rd_rvalid_o never rises, FIFO is empty, and the next read after reset has 2-cycle latency.
- Macro off: run the conflict scenario -> all perf_*_cnt_o read 0.
